// File: rtl/exp_lut_pkg.sv
// Shared definitions for the BF16 exp lookup-table loader.
// Table index layout is {E_adj, M, S}. E_adj covers exponents EMIN..EMAX.
// The hi table keeps 4 mantissa bits and the lo table keeps 3.
package exp_lut_pkg;

    localparam int          EMIN      = -7;
    localparam int          EMAX      = 6;
    localparam int unsigned E_BITS    = $clog2(EMAX - EMIN + 1);
    localparam int unsigned HI_M_BITS = 4;
    localparam int unsigned LO_M_BITS = 3;

    localparam int unsigned HI_AW    = E_BITS + HI_M_BITS + 1;
    localparam int unsigned LO_AW    = E_BITS + LO_M_BITS + 1;
    localparam int unsigned DW       = 16;
    localparam int unsigned HI_DEPTH = 1 << HI_AW;
    localparam int unsigned LO_DEPTH = 1 << LO_AW;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_HI,
        ST_LOAD_LO,
        ST_CHK,
        ST_DONE
    } state_t;

    // One accepted stream word, tagged with its destination table.
    typedef struct packed {
        logic             hi;
        logic             lo;
        logic [HI_AW-1:0] addr;
        logic [DW-1:0]    data;
    } wr_req_t;

    // States in which stream words are accepted.
    function automatic logic is_load(input state_t s);
        return (s == ST_LOAD_HI) || (s == ST_LOAD_LO) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/exp_lut_wr_stage.sv
// Registered write stage: turns an accepted word into a one-cycle
// we/addr/data pulse on the hi or lo table port.
// Ports: clk, rst (sync, active-high), req (accepted word),
//        hi_we/hi_waddr/hi_wdata, lo_we/lo_waddr/lo_wdata.
module exp_lut_wr_stage
    import exp_lut_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  wr_req_t          req,
    output logic             hi_we,
    output logic [HI_AW-1:0] hi_waddr,
    output logic [DW-1:0]    hi_wdata,
    output logic             lo_we,
    output logic [LO_AW-1:0] lo_waddr,
    output logic [DW-1:0]    lo_wdata
);

    wr_req_t q;

    // Enables pulse for one cycle; addr/data hold between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q.hi <= req.hi;
            q.lo <= req.lo;
            if (req.hi || req.lo) begin
                q.addr <= req.addr;
                q.data <= req.data;
            end
        end
    end

    assign hi_we    = q.hi;
    assign hi_waddr = q.addr;
    assign hi_wdata = q.data;
    assign lo_we    = q.lo;
    assign lo_waddr = q.addr[LO_AW-1:0];
    assign lo_wdata = q.data;

endmodule

// File: rtl/exp_lut_loader.sv
// Write side of the BF16 exp lookup tables. Streams HI_DEPTH words into the
// hi table and then LO_DEPTH words into the lo table. tables_valid is raised
// once both tables are complete.
// Optional feature macro EXP_LUT_CHECKSUM_EN: one trailing word carries the
// mod-2^16 sum of all table words, and a mismatch sets the sticky load_err.
// Ports: clk, rst (sync, active-high), start (reload pulse),
//        in_valid/in_data/in_ready (word stream),
//        hi_we/hi_waddr/hi_wdata, lo_we/lo_waddr/lo_wdata (table write ports),
//        busy, tables_valid, load_err.
module exp_lut_loader
    import exp_lut_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    output logic             in_ready,
    output logic             hi_we,
    output logic [HI_AW-1:0] hi_waddr,
    output logic [DW-1:0]    hi_wdata,
    output logic             lo_we,
    output logic [LO_AW-1:0] lo_waddr,
    output logic [DW-1:0]    lo_wdata,
    output logic             busy,
    output logic             tables_valid,
    output logic             load_err
);

`ifdef EXP_LUT_CHECKSUM_EN
    localparam state_t AFTER_LO = ST_CHK;
`else
    localparam state_t AFTER_LO = ST_DONE;
`endif

    state_t           state_q, state_d;
    logic [HI_AW-1:0] hi_cnt_q;
    logic [LO_AW-1:0] lo_cnt_q;
    logic             xfer;
    wr_req_t          req;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // start takes priority and blocks the transfer in its own cycle,
    // so an aborted load restarts cleanly at hi address 0.
    always_comb begin
        state_d  = state_q;
        in_ready = is_load(state_q) && !start;
        xfer     = in_valid && in_ready;
        req      = '0;

        req.hi   = xfer && (state_q == ST_LOAD_HI);
        req.lo   = xfer && (state_q == ST_LOAD_LO);
        req.addr = (state_q == ST_LOAD_HI) ? hi_cnt_q : HI_AW'(lo_cnt_q);
        req.data = in_data;

        if (start) begin
            state_d = ST_LOAD_HI;
        end else begin
            case (state_q)
                ST_LOAD_HI: if (req.hi && hi_cnt_q == HI_AW'(HI_DEPTH - 1)) state_d = ST_LOAD_LO;
                ST_LOAD_LO: if (req.lo && lo_cnt_q == LO_AW'(LO_DEPTH - 1)) state_d = AFTER_LO;
                ST_CHK:     if (xfer) state_d = ST_DONE;
                default:    ;
            endcase
        end
    end

    // Address counters wrap naturally at the last table address.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            hi_cnt_q <= '0;
            lo_cnt_q <= '0;
        end else begin
            if (req.hi) hi_cnt_q <= hi_cnt_q + HI_AW'(1);
            if (req.lo) lo_cnt_q <= lo_cnt_q + LO_AW'(1);
        end
    end

    // Busy covers the load states plus a write still in the output stage.
    always_ff @(posedge clk) begin
        if (rst) busy <= 1'b0;
        else     busy <= is_load(state_d) || req.hi || req.lo;
    end

    exp_lut_wr_stage u_wr_stage (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .hi_we    (hi_we),
        .hi_waddr (hi_waddr),
        .hi_wdata (hi_wdata),
        .lo_we    (lo_we),
        .lo_waddr (lo_waddr),
        .lo_wdata (lo_wdata)
    );

`ifdef EXP_LUT_CHECKSUM_EN
    logic [DW-1:0] sum_q;

    // Running mod-2^16 sum of every table word of the current load.
    always_ff @(posedge clk) begin
        if (rst || start)            sum_q <= '0;
        else if (req.hi || req.lo)   sum_q <= sum_q + in_data;
    end

    // The trailing checksum word decides between valid tables and error.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            tables_valid <= 1'b0;
            load_err     <= 1'b0;
        end else if (xfer && state_q == ST_CHK) begin
            if (in_data == sum_q) tables_valid <= 1'b1;
            else                  load_err     <= 1'b1;
        end
    end
`else
    // Valid once the final lo-table write has left the output stage.
    always_ff @(posedge clk) begin
        if (rst || start)                                  tables_valid <= 1'b0;
        else if (lo_we && lo_waddr == LO_AW'(LO_DEPTH - 1)) tables_valid <= 1'b1;
    end

    assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_exp_lut_loader.sv
// Self-checking bench for exp_lut_loader. A word-index model predicts every
// output each cycle; literal checks pin reset, abort, checksum and DONE cases.
module tb_exp_lut_loader;
    import exp_lut_pkg::*;

`ifdef EXP_LUT_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    localparam int NHI        = int'(HI_DEPTH);
    localparam int NLO        = int'(LO_DEPTH);
    localparam int WORDS      = NHI + NLO;
    localparam int LOAD_WORDS = WORDS + (CHK_EN ? 1 : 0);

    logic             clk = 1'b0;
    logic             rst, start, in_valid;
    logic [DW-1:0]    in_data;
    logic             in_ready, hi_we, lo_we, busy, tables_valid, load_err;
    logic [HI_AW-1:0] hi_waddr;
    logic [LO_AW-1:0] lo_waddr;
    logic [DW-1:0]    hi_wdata, lo_wdata;

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] words [0:WORDS];

    exp_lut_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .hi_we        (hi_we),
        .hi_waddr     (hi_waddr),
        .hi_wdata     (hi_wdata),
        .lo_we        (lo_we),
        .lo_waddr     (lo_waddr),
        .lo_wdata     (lo_wdata),
        .busy         (busy),
        .tables_valid (tables_valid),
        .load_err     (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: a load is a run of word indices 0..WORDS-1
    // (plus the checksum word); index < NHI goes to hi, the rest to lo.
    bit            m_loading = 0, m_tv = 0, m_err = 0, m_hwe = 0, m_lwe = 0;
    int            m_widx = 0, m_addr = 0;
    logic [DW-1:0] m_sum = '0, m_data = '0;

    always begin
        bit x, set_tv;
        @(posedge clk);
        x      = in_valid && m_loading && !start;
        set_tv = !CHK_EN && m_lwe && (m_addr == NLO - 1);
        if (rst) begin
            m_loading = 0; m_tv = 0; m_err = 0; m_hwe = 0; m_lwe = 0;
            m_widx = 0; m_sum = '0;
        end else begin
            m_hwe = x && (m_widx < NHI);
            m_lwe = x && (m_widx >= NHI) && (m_widx < WORDS);
            if (m_hwe) begin m_addr = m_widx;       m_data = in_data; end
            if (m_lwe) begin m_addr = m_widx - NHI; m_data = in_data; end
            if (start) begin
                m_loading = 1; m_widx = 0; m_sum = '0; m_tv = 0; m_err = 0;
            end else begin
                if (set_tv) m_tv = 1;
                if (x) begin
                    if (m_widx < WORDS)       m_sum = m_sum + in_data;
                    else if (in_data == m_sum) m_tv = 1;
                    else                       m_err = 1;
                    m_widx++;
                    if (m_widx == LOAD_WORDS) m_loading = 0;
                end
            end
        end
        #1;
        check("in_ready", int'(in_ready), int'(m_loading && !start));
        check("hi_we", int'(hi_we), int'(m_hwe));
        check("lo_we", int'(lo_we), int'(m_lwe));
        check("we_exclusive", int'(hi_we && lo_we), 0);
        if (m_hwe) begin
            check("hi_waddr", int'(hi_waddr), m_addr);
            check("hi_wdata", int'(hi_wdata), int'(m_data));
        end
        if (m_lwe) begin
            check("lo_waddr", int'(lo_waddr), m_addr);
            check("lo_wdata", int'(lo_wdata), int'(m_data));
        end
        check("busy", int'(busy), int'(m_loading || m_hwe || m_lwe));
        check("tables_valid", int'(tables_valid), int'(m_tv));
        check("load_err", int'(load_err), int'(m_err));
    end

    // kind 0: data = table address, 1: random, 2: all 16'h3f80.
    task automatic prep(input int kind);
        logic [DW-1:0] s;
        s = '0;
        for (int i = 0; i < WORDS; i++) begin
            case (kind)
                0:       words[i] = DW'((i < NHI) ? i : i - NHI);
                1:       words[i] = DW'($urandom);
                default: words[i] = 16'h3f80;
            endcase
            s = s + words[i];
        end
        words[WORDS] = s;
    endtask

    // Called and returns at a negedge. mode 0: back-to-back, 1: valid
    // toggling, 2: random valid. Returns one negedge after the last transfer.
    task automatic send_range(input int first, input int last, input int mode);
        int i, stall;
        bit phase, v;
        i = first; stall = 0; phase = 0;
        while (i < last) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? !phase : ($urandom_range(0, 1) == 1);
            phase = !phase;
            in_valid = v;
            in_data  = v ? words[i] : DW'($urandom);
            #1;
            if (in_valid && in_ready) begin
                i++; stall = 0;
            end else begin
                stall++;
                if (stall > 64) begin
                    check("stall_timeout", i, last);
                    i = last;
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        @(negedge clk); @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_tables_valid", int'(tables_valid), 0);
        check("rst_hi_we", int'(hi_we), 0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back load with data = address.
        prep(0);
        pulse_start();
        send_range(0, WORDS, 0);
        check("s1_last_lo_we", int'(lo_we), 1);
        check("s1_last_lo_waddr", int'(lo_waddr), 255);
        check("s1_tv_low_at_last_write", int'(tables_valid), 0);
`ifdef EXP_LUT_CHECKSUM_EN
        send_range(WORDS, WORDS + 1, 0);
`else
        @(negedge clk);
`endif
        check("s1_tv_high", int'(tables_valid), 1);
        repeat (3) @(negedge clk);

        // in_valid toggling every cycle.
        pulse_start();
        send_range(0, LOAD_WORDS, 1);
        repeat (3) @(negedge clk);
        check("s2_tv_high", int'(tables_valid), 1);

        // Abort at hi word 100 with in_valid high during start.
        prep(1);
        pulse_start();
        send_range(0, 100, 0);
        in_valid = 1'b1; in_data = 16'hdead;
        pulse_start();
        in_valid = 1'b0;
        check("s3_no_write_on_start", int'(hi_we), 0);
        check("s3_tv_cleared", int'(tables_valid), 0);
        send_range(0, 1, 0);
        check("s3_restart_we", int'(hi_we), 1);
        check("s3_restart_addr0", int'(hi_waddr), 0);
        send_range(1, LOAD_WORDS, 2);
        repeat (3) @(negedge clk);
        check("s3_tv_after_full", int'(tables_valid), 1);

        // Reset during lo word 40.
        pulse_start();
        send_range(0, NHI + 40, 2);
        rst = 1'b1; in_valid = 1'b1; in_data = 16'h1234;
        @(negedge clk);
        check("s4_hi_we", int'(hi_we), 0);
        check("s4_lo_we", int'(lo_we), 0);
        check("s4_hi_waddr", int'(hi_waddr), 0);
        check("s4_lo_waddr", int'(lo_waddr), 0);
        check("s4_hi_wdata", int'(hi_wdata), 0);
        check("s4_busy", int'(busy), 0);
        check("s4_tv", int'(tables_valid), 0);
        check("s4_err", int'(load_err), 0);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("s4_in_ready_idle", int'(in_ready), 0);
        end
        in_valid = 1'b0;

        // Random data, random valid.
        prep(1);
        pulse_start();
        send_range(0, LOAD_WORDS, 2);
        repeat (3) @(negedge clk);
        check("rand_tv_high", int'(tables_valid), 1);

        // Words presented in DONE are ignored.
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; in_data = DW'($urandom);
            @(negedge clk);
        end
        check("s6_in_ready", int'(in_ready), 0);
        check("s6_tv_stays", int'(tables_valid), 1);
        // start in DONE with in_valid high transfers nothing.
        pulse_start();
        in_valid = 1'b0;
        check("s6_start_no_we", int'(hi_we), 0);
        check("s6_start_tv_clr", int'(tables_valid), 0);
        repeat (2) @(negedge clk);

`ifdef EXP_LUT_CHECKSUM_EN
        // 768 * 16'h3f80 = 0xBE8000, so the mod-2^16 sum is 16'h8000.
        prep(2);
        words[WORDS] = 16'h8000;
        pulse_start();
        send_range(0, LOAD_WORDS, 0);
        check("s5_good_tv", int'(tables_valid), 1);
        check("s5_good_err", int'(load_err), 0);
        words[WORDS] = 16'h0001;
        pulse_start();
        send_range(0, LOAD_WORDS, 0);
        check("s5_bad_err", int'(load_err), 1);
        check("s5_bad_tv", int'(tables_valid), 0);
        repeat (2) @(negedge clk);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
